// File: rtl/param_gcd.sv
// param_gcd: binary (Stein) GCD with valid/ready handshakes; optional CALC cycle counter via PARAM_GCD_CYCLE_COUNT_EN
module param_gcd #(
  parameter int WIDTH = 36,
  parameter int KW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
`ifdef PARAM_GCD_CYCLE_COUNT_EN
  ,
  output logic [15:0]      cycles
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] x, y, x_n, y_n, res_n;
  logic [KW-1:0] k, k_n;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // one Stein step per CALC cycle; k counts the shared factors of two restored at the end
  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    k_n = k;
    res_n = res;
    case (state)
      IDLE: if (in_valid) begin
        x_n = a;
        y_n = b;
        k_n = '0;
        state_n = CALC;
      end
      CALC: begin
        if (x == '0) begin
          res_n = y << k;
          state_n = DONE;
        end else if (y == '0) begin
          res_n = x << k;
          state_n = DONE;
        end else if (!x[0] && !y[0]) begin
          x_n = x >> 1;
          y_n = y >> 1;
          k_n = k + 1'b1;
        end else if (!x[0]) x_n = x >> 1;
        else if (!y[0]) y_n = y >> 1;
        else if (x >= y) x_n = (x - y) >> 1;
        else y_n = (y - x) >> 1;
      end
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers; reset discards any pending result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      k <= '0;
      res <= '0;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      k <= k_n;
      res <= res_n;
    end
  end
`ifdef PARAM_GCD_CYCLE_COUNT_EN
  // saturating count of CALC cycles, cleared on accept, frozen outside CALC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycles <= '0;
    else if (state == IDLE && in_valid) cycles <= '0;
    else if (state == CALC && cycles != 16'hFFFF) cycles <= cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_param_gcd.sv
// tb_param_gcd: directed and random checks of param_gcd at WIDTH=36 and WIDTH=8
module tb_param_gcd;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic iv36 = 1'b0, or36 = 1'b1, iv8 = 1'b0, or8 = 1'b1;
  logic ir36, ov36, ir8, ov8;
  logic [35:0] a36 = '0, b36 = '0, res36;
  logic [7:0] a8 = '0, b8 = '0, res8;
  int errors = 0, checks = 0;
`ifdef PARAM_GCD_CYCLE_COUNT_EN
  logic [15:0] cyc36, cyc8;
`endif

  always #5 clk = ~clk;

  param_gcd #(.WIDTH(36)) d36 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv36), .in_ready(ir36), .a(a36), .b(b36),
    .out_valid(ov36), .out_ready(or36), .res(res36)
`ifdef PARAM_GCD_CYCLE_COUNT_EN
    , .cycles(cyc36)
`endif
  );

  param_gcd #(.WIDTH(8)) d8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .res(res8)
`ifdef PARAM_GCD_CYCLE_COUNT_EN
    , .cycles(cyc8)
`endif
  );

  function automatic logic [63:0] gcd_ref(input logic [63:0] p, input logic [63:0] q);
    logic [63:0] t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called just after the accept edge; returns at the first negedge showing out_valid
  task automatic wait_res(input logic [35:0] exp, input int lat, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) iv36 = 1'b0;
    end while (!ov36 && n < 300);
    chk({tag, " out_valid"}, 64'(ov36), 64'd1);
    chk({tag, " res"}, 64'(res36), 64'(exp));
    chk({tag, " in_ready in DONE"}, 64'(ir36), 64'd0);
    if (lat > 0) chk({tag, " latency"}, 64'(n), 64'(lat));
`ifdef PARAM_GCD_CYCLE_COUNT_EN
    chk({tag, " cycles"}, 64'(cyc36), 64'(n - 1));
`endif
  endtask

  // called at a negedge with out_ready=1
  task automatic op36(input logic [35:0] a, input logic [35:0] b, input logic [35:0] exp,
                      input int lat, input string tag);
    chk({tag, " in_ready idle"}, 64'(ir36), 64'd1);
    a36 = a;
    b36 = b;
    iv36 = 1'b1;
    @(posedge clk);
    wait_res(exp, lat, tag);
    @(negedge clk);
    chk({tag, " back to idle"}, 64'(ir36), 64'd1);
  endtask

  initial begin
    logic [35:0] ra36, rb36, keep;
    logic [7:0] ra8, rb8;
    logic d8f, d36f;
    int c8, c36, t;
    #12;
    chk("reset in_ready", 64'(ir36), 64'd1);
    chk("reset out_valid", 64'(ov36), 64'd0);
    chk("reset res", 64'(res36), 64'd0);
`ifdef PARAM_GCD_CYCLE_COUNT_EN
    chk("reset cycles", 64'(cyc36), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    op36(36'd12, 36'd18, 36'd6, 6, "s1 12,18");
    op36(36'd0, 36'd0, 36'd0, 2, "s2 0,0");
    op36(36'd0, 36'd35, 36'd35, 2, "s2 0,35");
    op36(36'd35, 36'd0, 36'd35, 2, "s2 35,0");
    op36(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, -1, "s3 ones");
    op36(36'h8_0000_0000, 36'h0_0010_0000, 36'h0_0010_0000, -1, "s3 pow2");
    op36(36'd17, 36'd5, 36'd1, -1, "coprime");
    // hold the result in DONE while new requests are presented
    or36 = 1'b0;
    a36 = 36'd12;
    b36 = 36'd18;
    iv36 = 1'b1;
    @(posedge clk);
    wait_res(36'd6, 6, "s4");
    keep = res36;
    for (int i = 0; i < 10; i++) begin
      a36 = 36'(i * 7 + 3);
      b36 = 36'(i * 5 + 1);
      iv36 = 1'b1;
      @(negedge clk);
      chk("s4 hold out_valid", 64'(ov36), 64'd1);
      chk("s4 hold res", 64'(res36), 64'(keep));
      chk("s4 hold in_ready", 64'(ir36), 64'd0);
    end
    or36 = 1'b1;
    a36 = 36'd48;
    b36 = 36'd180;
    @(negedge clk);
    chk("s4 idle after release", 64'(ir36), 64'd1);
    chk("s4 out_valid dropped", 64'(ov36), 64'd0);
    @(posedge clk);
    wait_res(36'd12, -1, "s4 next");
    @(negedge clk);
    // asynchronous reset in the middle of a long computation
    a36 = 36'h8_0000_0000;
    b36 = 36'd3;
    iv36 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv36 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("s5 busy before reset", 64'(ir36), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("s5 reset out_valid", 64'(ov36), 64'd0);
    chk("s5 reset in_ready", 64'(ir36), 64'd1);
    chk("s5 reset res", 64'(res36), 64'd0);
    a36 = 36'd48;
    b36 = 36'd180;
    iv36 = 1'b1;
    #1 reset_n = 1'b1;
    @(posedge clk);
    wait_res(36'd12, -1, "s5 48,180");
    @(negedge clk);
    // random pairs on both widths in lockstep with random out_ready
    for (int i = 0; i < 1000; i++) begin
      ra36 = 36'({$urandom, $urandom});
      rb36 = 36'({$urandom, $urandom});
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      if ($urandom_range(15) == 0) ra36 = '0;
      if ($urandom_range(15) == 0) rb8 = '0;
      a36 = ra36;
      b36 = rb36;
      a8 = ra8;
      b8 = rb8;
      iv36 = 1'b1;
      iv8 = 1'b1;
      @(posedge clk);
      d8f = 1'b0;
      d36f = 1'b0;
      c8 = 0;
      c36 = 0;
      t = 0;
      while (!(d8f && d36f && ir8 && ir36) && t < 400) begin
        @(negedge clk);
        t++;
        iv36 = 1'b0;
        iv8 = 1'b0;
        if (!ir8 && !ov8) c8++;
        if (!ir36 && !ov36) c36++;
        if (ov8 && !d8f) begin
          d8f = 1'b1;
          chk("s6 w8 res", 64'(res8), gcd_ref(64'(ra8), 64'(rb8)));
          chk("s6 w8 occupancy ok", 64'(c8 <= 17), 64'd1);
        end
        if (ov36 && !d36f) begin
          d36f = 1'b1;
          chk("s6 w36 res", 64'(res36), gcd_ref(64'(ra36), 64'(rb36)));
          chk("s6 w36 occupancy ok", 64'(c36 <= 73), 64'd1);
        end
        or8 = 1'($urandom);
        or36 = 1'($urandom);
      end
      if (t >= 400) chk("s6 timeout", 64'(t), 64'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
